// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage: instruction codes, status
// codes, fetch FSM states and instruction-format decode helpers.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Register id meaning "no register"
  localparam logic [3:0] REG_NONE = 4'hF;

  // Number of little-endian bytes in valC
  localparam int CONST_BYTES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BYTE0,
    S_REGS,
    S_CONST,
    S_DONE
  } fetch_state_e;

  // Instruction carries a register-specifier byte
  function automatic logic need_regids(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      default:                need_regids = 1'b0;
    endcase
  endfunction

  // Instruction carries an 8-byte constant
  function automatic logic need_valC(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: need_valC = 1'b1;
      default:                                     need_valC = 1'b0;
    endcase
  endfunction

  // Legal icode/ifun combination; any icode above POPQ is illegal
  function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_OPQ:            ifun_ok = (ifun <= 4'd3);
      I_RRMOVQ, I_JXX:  ifun_ok = (ifun <= 4'd6);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ: ifun_ok = (ifun == 4'd0);
      default:          ifun_ok = 1'b0;
    endcase
  endfunction

  // Address of the following instruction, wrapping mod 2^64
  function automatic logic [63:0] calc_valp(input logic [63:0] pc, input logic [3:0] icode);
    calc_valp = pc + 64'd1 + {63'd0, need_regids(icode)}
                + (need_valC(icode) ? 64'd8 : 64'd0);
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Constant-byte assembler: counts the valC bytes received so far and drops
// each one into its little-endian lane of the 64-bit constant.
module fetch_align
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] valC_o,
  output logic        lastByte_o
);

  logic [2:0]  byteCnt_q;
  logic [63:0] valC_q;

  // Clear at the start of each fetch, then fill one byte lane per accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt_q <= 3'd0;
      valC_q    <= 64'd0;
    end else if (clear_i) begin
      byteCnt_q <= 3'd0;
      valC_q    <= 64'd0;
    end else if (load_i) begin
      valC_q[{byteCnt_q, 3'b000} +: 8] <= byte_i;
      byteCnt_q                        <= byteCnt_q + 3'd1;
    end
  end

  assign valC_o     = valC_q;
  assign lastByte_o = (byteCnt_q == 3'(CONST_BYTES - 1));

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch stage: holds the PC, reads an instruction one byte at a
// time over a req/ack memory port and splits it into decode fields.
module fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned IMEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load_i,
  input  logic [63:0] new_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic [7:0]  imem_rdata_i,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  output logic [63:0] pc_o,
  output logic [3:0]  icode_o,
  output logic [3:0]  ifun_o,
  output logic [3:0]  rA_o,
  output logic [3:0]  rB_o,
  output logic [63:0] valC_o,
  output logic [63:0] valP_o,
  output logic [2:0]  stat_o,
  output logic        busy_o,
  output logic        fetch_done_o
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_SIZE);

  fetch_state_e state_q;
  logic [63:0]  pc_q;
  logic [63:0]  addr_q;
  logic [63:0]  valP_q;
  logic [3:0]   icode_q;
  logic [3:0]   ifun_q;
  logic [3:0]   rA_q;
  logic [3:0]   rB_q;
  logic [2:0]   stat_q;
  logic         req_q;
  logic         busy_q;
  logic         fetchDone_q;

  logic         startFetch;
  logic         accepted;
  logic         constLoad;
  logic [3:0]   ackIcode;
  logic [63:0]  nextAddr;
  logic         nextInRange;
  logic         finishNow;
  logic         goRegs;
  logic         goConst;
  logic [2:0]   finishStat;
  logic         lastByte;
  logic [63:0]  valC;

  assign startFetch = pc_load_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accepted   = req_q && imem_ack_i;
  assign constLoad  = accepted && !imem_err_i && (state_q == S_CONST);
  assign nextAddr   = addr_q + 64'd1;
  assign nextInRange = (nextAddr < IMEM_LIMIT);

  fetch_align u_align (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (startFetch),
    .load_i     (constLoad),
    .byte_i     (imem_rdata_i),
    .valC_o     (valC),
    .lastByte_o (lastByte)
  );

  // Decide what the current ack leads to: another byte, or the end of the fetch
  always_comb begin
    finishNow  = 1'b0;
    goRegs     = 1'b0;
    goConst    = 1'b0;
    finishStat = STAT_AOK;
    ackIcode   = icode_q;
    if ((state_q == S_BYTE0) && !imem_err_i) begin
      ackIcode = imem_rdata_i[7:4];
    end
    if (accepted) begin
      if (imem_err_i) begin
        finishNow  = 1'b1;
        finishStat = STAT_ADR;
      end else begin
        case (state_q)
          S_BYTE0: begin
            if (!ifun_ok(imem_rdata_i[7:4], imem_rdata_i[3:0])) begin
              finishNow  = 1'b1;
              finishStat = STAT_INS;
            end else if (imem_rdata_i[7:4] == I_HALT) begin
              finishNow  = 1'b1;
              finishStat = STAT_HLT;
            end else if (need_regids(imem_rdata_i[7:4])) begin
              goRegs = 1'b1;
            end else if (need_valC(imem_rdata_i[7:4])) begin
              goConst = 1'b1;
            end else begin
              finishNow = 1'b1;
            end
          end
          S_REGS: begin
            if (need_valC(icode_q)) goConst   = 1'b1;
            else                    finishNow = 1'b1;
          end
          S_CONST: begin
            if (lastByte) finishNow = 1'b1;
            else          goConst   = 1'b1;
          end
          default: begin
            finishNow = 1'b0;
          end
        endcase
        // A following byte beyond the end of memory is never requested
        if ((goRegs || goConst) && !nextInRange) begin
          goRegs     = 1'b0;
          goConst    = 1'b0;
          finishNow  = 1'b1;
          finishStat = STAT_ADR;
        end
      end
    end
  end

  // Fetch FSM with registered request, status and decode-field outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= 64'd0;
      valP_q      <= 64'd0;
      icode_q     <= I_NOP;
      ifun_q      <= 4'd0;
      rA_q        <= REG_NONE;
      rB_q        <= REG_NONE;
      stat_q      <= STAT_AOK;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      fetchDone_q <= 1'b0;
    end else begin
      fetchDone_q <= 1'b0;
      if (accepted) req_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (startFetch) begin
            pc_q    <= new_pc_i;
            icode_q <= I_NOP;
            ifun_q  <= 4'd0;
            rA_q    <= REG_NONE;
            rB_q    <= REG_NONE;
            stat_q  <= STAT_AOK;
            if (new_pc_i >= IMEM_LIMIT) begin
              state_q     <= S_DONE;
              stat_q      <= STAT_ADR;
              valP_q      <= calc_valp(new_pc_i, I_NOP);
              fetchDone_q <= 1'b1;
            end else begin
              state_q <= S_BYTE0;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              addr_q  <= new_pc_i;
            end
          end
        end
        S_BYTE0: begin
          if (accepted && !imem_err_i) begin
            icode_q <= imem_rdata_i[7:4];
            ifun_q  <= imem_rdata_i[3:0];
          end
        end
        S_REGS: begin
          if (accepted && !imem_err_i) begin
            rA_q <= imem_rdata_i[7:4];
            rB_q <= imem_rdata_i[3:0];
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase

      if (finishNow) begin
        state_q     <= S_DONE;
        busy_q      <= 1'b0;
        fetchDone_q <= 1'b1;
        stat_q      <= finishStat;
        valP_q      <= calc_valp(pc_q, ackIcode);
      end else if (goRegs) begin
        state_q <= S_REGS;
        req_q   <= 1'b1;
        addr_q  <= nextAddr;
      end else if (goConst) begin
        state_q <= S_CONST;
        req_q   <= 1'b1;
        addr_q  <= nextAddr;
      end
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign pc_o         = pc_q;
  assign icode_o      = icode_q;
  assign ifun_o       = ifun_q;
  assign rA_o         = rA_q;
  assign rB_o         = rB_q;
  assign valC_o       = valC;
  assign valP_o       = valP_q;
  assign stat_o       = stat_q;
  assign busy_o       = busy_q;
  assign fetch_done_o = fetchDone_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected decode of
// each fetch, a monitor pops and compares on every fetch_done pulse, and a
// byte-memory responder checks the request address on every access.
module tb_fetch_unit;

  localparam int MEM_BYTES = 4096;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;
    int          lat;
    int          start;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pc_load;
  logic [63:0] new_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_ack;
  logic        imem_err;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;
  logic        busy;
  logic        fetchDone;

  logic [7:0]  mem [0:MEM_BYTES-1];
  exp_t        expQ[$];
  exp_t        monExp;
  int          checks;
  int          errors;
  int          cycleCnt;
  int          waitCycles;
  int          errAtAck;
  int          ackNum;
  int          waitCnt;
  logic [63:0] holdAddr;

  fetch_unit #(
    .RESET_PC  (64'h0),
    .IMEM_SIZE (MEM_BYTES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_load_i    (pc_load),
    .new_pc_i     (new_pc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .imem_ack_i   (imem_ack),
    .imem_err_i   (imem_err),
    .pc_o         (pc),
    .icode_o      (icode),
    .ifun_o       (ifun),
    .rA_o         (rA),
    .rB_o         (rB),
    .valC_o       (valC),
    .valP_o       (valP),
    .stat_o       (stat),
    .busy_o       (busy),
    .fetch_done_o (fetchDone)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure pc_load to fetch_done latency
  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] readMem(input logic [63:0] addr);
    if (addr < 64'(MEM_BYTES)) readMem = mem[addr[11:0]];
    else                       readMem = 8'h00;
  endfunction

  function automatic exp_t mkExp(input logic [63:0] p, input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                                 input logic [63:0] vp, input logic [2:0] st, input int lat);
    mkExp.pc = p;   mkExp.icode = ic; mkExp.ifun = fn;
    mkExp.rA = ra;  mkExp.rB = rb;    mkExp.valC = vc;
    mkExp.valP = vp; mkExp.stat = st; mkExp.lat = lat; mkExp.start = 0;
  endfunction

  // Memory responder: ack after waitCycles idle cycles, optional error on one ack
  always @(negedge clk) begin
    if (imem_req) begin
      if (waitCnt == 0) begin
        holdAddr = imem_addr;
        checkOutput("reqInRange", {63'd0, (imem_addr < 64'(MEM_BYTES))}, 64'd1);
      end else begin
        checkOutput("addrStable", imem_addr, holdAddr);
      end
      if (waitCnt >= waitCycles) begin
        ackNum++;
        imem_ack   = 1'b1;
        imem_rdata = readMem(imem_addr);
        imem_err   = (ackNum == errAtAck);
        waitCnt    = 0;
      end else begin
        imem_ack = 1'b0;
        imem_err = 1'b0;
        waitCnt++;
      end
    end else begin
      imem_ack = 1'b0;
      imem_err = 1'b0;
      waitCnt  = 0;
    end
  end

  // Monitor: every fetch_done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && fetchDone) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got fetch_done=1 at pc 0x%0h, expected no pulse", pc);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pc",      pc,    monExp.pc);
        checkOutput("icode",   {60'd0, icode}, {60'd0, monExp.icode});
        checkOutput("ifun",    {60'd0, ifun},  {60'd0, monExp.ifun});
        checkOutput("rA",      {60'd0, rA},    {60'd0, monExp.rA});
        checkOutput("rB",      {60'd0, rB},    {60'd0, monExp.rB});
        checkOutput("valC",    valC,  monExp.valC);
        checkOutput("valP",    valP,  monExp.valP);
        checkOutput("stat",    {61'd0, stat},  {61'd0, monExp.stat});
        checkOutput("busyAtDone", {63'd0, busy}, 64'd0);
        checkOutput("latency", 64'(cycleCnt - monExp.start), 64'(monExp.lat));
      end
    end
  end

  task automatic loadMem(input logic [63:0] base, input logic [79:0] bytes, input int n);
    for (int i = 0; i < n; i++) mem[base[11:0] + 12'(i)] = bytes[79-8*i -: 8];
  endtask

  task automatic issueFetch(input exp_t e);
    exp_t q;
    q = e;
    @(negedge clk);
    q.start = cycleCnt;
    expQ.push_back(q);
    pc_load = 1'b1;
    new_pc  = e.pc;
    @(posedge clk);
    #1 pc_load = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL doneTimeout: got %0d pending fetches after 200 cycles, expected 0", expQ.size());
      expQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input exp_t e);
    issueFetch(e);
    waitIdle();
  endtask

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int reqBefore;
    checks = 0; errors = 0;
    waitCycles = 0; errAtAck = 0; ackNum = 0; waitCnt = 0; holdAddr = 64'd0;
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = 8'h00;
    pc_load = 1'b0; new_pc = 64'd0;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstPc",    pc, 64'd0);
    checkOutput("rstIcode", {60'd0, icode}, 64'd1);
    checkOutput("rstStat",  {61'd0, stat}, 64'd1);
    checkOutput("rstBusy",  {63'd0, busy}, 64'd0);
    checkOutput("rstReq",   {63'd0, imem_req}, 64'd0);
    checkOutput("rstRa",    {60'd0, rA}, 64'hF);
    checkOutput("rstValP",  valP, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("noFetchBeforeLoad", {63'd0, imem_req}, 64'd0);

    // 10-byte irmovq
    loadMem(64'h10, 80'h30F3EFCDAB8967452301, 10);
    applyStimulus(mkExp(64'h10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h1A, 3'd1, 11));

    // ret, zero-wait then two wait cycles per ack
    loadMem(64'h20, {8'h90, 72'h0}, 1);
    applyStimulus(mkExp(64'h20, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 3'd1, 2));
    waitCycles = 2;
    applyStimulus(mkExp(64'h20, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 3'd1, 4));
    waitCycles = 0;

    // Illegal icode, single request only
    loadMem(64'h30, {8'hC0, 72'h0}, 1);
    reqBefore = ackNum;
    applyStimulus(mkExp(64'h30, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h31, 3'd4, 2));
    checkOutput("insReqCount", 64'(ackNum - reqBefore), 64'd1);

    // OPq with out-of-range ifun
    loadMem(64'h40, {8'h64, 72'h0}, 1);
    applyStimulus(mkExp(64'h40, 4'h6, 4'h4, 4'hF, 4'hF, 64'h0, 64'h42, 3'd4, 2));

    // halt and a 2-byte addq
    loadMem(64'h50, {8'h00, 72'h0}, 1);
    applyStimulus(mkExp(64'h50, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 3'd2, 2));
    loadMem(64'h60, {16'h6012, 64'h0}, 2);
    applyStimulus(mkExp(64'h60, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h62, 3'd1, 3));

    // jXX straddling the end of memory
    loadMem(64'hFFE, {16'h7011, 64'h0}, 2);
    reqBefore = ackNum;
    applyStimulus(mkExp(64'hFFE, 4'h7, 4'h0, 4'hF, 4'hF, 64'h11, 64'h1007, 3'd3, 3));
    checkOutput("adrReqCount", 64'(ackNum - reqBefore), 64'd2);

    // Memory error on the third ack
    loadMem(64'h80, 80'h30F3_1122334455667788, 10);
    errAtAck = ackNum + 3;
    applyStimulus(mkExp(64'h80, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0, 64'h8A, 3'd3, 4));
    errAtAck = 0;

    // pc_load while busy is ignored
    issueFetch(mkExp(64'h10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h1A, 3'd1, 11));
    repeat (2) @(negedge clk);
    pc_load = 1'b1; new_pc = 64'h99;
    @(posedge clk);
    #1 pc_load = 1'b0;
    checkOutput("busyIgnorePc", pc, 64'h10);
    checkOutput("busyIgnoreBusy", {63'd0, busy}, 64'd1);
    waitIdle();

    // Reset in the middle of the constant bytes
    @(negedge clk);
    pc_load = 1'b1; new_pc = 64'h10;
    @(posedge clk);
    #1 pc_load = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("midBusy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq",   {63'd0, imem_req}, 64'd0);
    checkOutput("midRstPc",    pc, 64'd0);
    checkOutput("midRstIcode", {60'd0, icode}, 64'd1);
    checkOutput("midRstValC",  valC, 64'd0);
    checkOutput("midRstRb",    {60'd0, rB}, 64'hF);
    checkOutput("midRstBusy",  {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("postRstReq", {63'd0, imem_req}, 64'd0);

    // Out-of-range PC with wrapping valP; nothing is requested
    reqBefore = ackNum;
    applyStimulus(mkExp(64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3, 1));
    checkOutput("wrapReqCount", 64'(ackNum - reqBefore), 64'd0);
    checkOutput("holdPc", pc, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
